// File: rtl/stutter_codeblock_param_pkg.sv
// Shared pc encoding and mode constants for the stuttering code-block model.
package codeblock_pkg;

  localparam logic [3:0] INIT = 4'd0;
  localparam logic [3:0] BR   = 4'd1;
  localparam logic [3:0] A1   = 4'd2;
  localparam logic [3:0] B1   = 4'd3;
  localparam logic [3:0] BR2  = 4'd4;
  localparam logic [3:0] A2   = 4'd5;
  localparam logic [3:0] B2   = 4'd6;
  localparam logic [3:0] A3   = 4'd7;
  localparam logic [3:0] B3   = 4'd8;
  localparam logic [3:0] DONE = 4'd9;
  localparam logic [3:0] T_A  = 4'd10;
  localparam logic [3:0] T_B  = 4'd11;

  localparam logic MODE_SOURCE = 1'b0;
  localparam logic MODE_TARGET = 1'b1;

endpackage

// File: rtl/stutter_codeblock_param_if.sv
// Harness-facing bundle: run controls and operands in, computed results and pc out.
interface stutter_codeblock_param_if #(
  parameter int W  = 2,
  parameter int N  = 2,
  parameter int IW = (N > 2) ? $clog2(N) : 1
) ();

  logic              stutter_in;
  logic              start;
  logic              mode;
  logic [IW-1:0]     j;
  logic [IW-1:0]     arr_size;
  logic [N*W-1:0]    arr;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              stutter;
  logic              done;
  logic [3:0]        pc;

  modport master (
    output stutter_in, start, mode, j, arr_size, arr,
    input  a, b, stutter, done, pc
  );

  modport slave (
    input  stutter_in, start, mode, j, arr_size, arr,
    output a, b, stutter, done, pc
  );

endinterface

// File: rtl/stutter_codeblock_param_alu.sv
// Combinational datapath: bounded array read and the a = f(arr[0], arr[1]) function.
module codeblock_alu #(
  parameter int W  = 2,
  parameter int N  = 2,
  parameter int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic [IW-1:0]  idx,
  input  logic [N*W-1:0] arr,
  output logic [W-1:0]   elem,
  output logic [W-1:0]   a_val
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [W-1:0] inc;

  assign e0  = arr[0 +: W];
  assign e1  = arr[W +: W];
  assign inc = e0 + W'(1);

  // (arr1 - 1) mod 2 is just the inverted lsb of arr1, so the product collapses to a mux.
  assign a_val = e1[0] ? '0 : (inc << 1);

  always_comb begin
    elem = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == IW'(k)) elem = arr[k*W +: W];
    end
  end

endmodule

// File: rtl/stutter_codeblock_param.sv
// Stuttering array program: source (branch + dead branch) or hoisted target control flow.
module stutter_codeblock_param
  import codeblock_pkg::*;
#(
  parameter int W  = 2,
  parameter int N  = 2,
  parameter int IW = (N > 2) ? $clog2(N) : 1
) (
  input logic                      clk,
  input logic                      rst,
  stutter_codeblock_param_if.slave bus
);

  logic [3:0]     pc_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           stutter_q;
  logic           done_q;
  logic [IW-1:0]  j_q;
  logic [IW-1:0]  size_q;
  logic [N*W-1:0] arr_q;
  logic           mode_q;

  logic [W-1:0]   elem_j;
  logic [W-1:0]   elem_s;
  logic [W-1:0]   a_j;
  logic [W-1:0]   a_s;

  codeblock_alu #(.W(W), .N(N), .IW(IW)) u_alu_j (
    .idx   (j_q),
    .arr   (arr_q),
    .elem  (elem_j),
    .a_val (a_j)
  );

  codeblock_alu #(.W(W), .N(N), .IW(IW)) u_alu_s (
    .idx   (size_q),
    .arr   (arr_q),
    .elem  (elem_s),
    .a_val (a_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= INIT;
      a_q       <= '0;
      b_q       <= '0;
      stutter_q <= 1'b0;
      done_q    <= 1'b0;
      j_q       <= '0;
      size_q    <= '0;
      arr_q     <= '0;
      mode_q    <= MODE_SOURCE;
    end else begin
      stutter_q <= bus.stutter_in;
      if (!bus.stutter_in) begin
        done_q <= 1'b0;
        case (pc_q)
          INIT: begin
            j_q    <= bus.j;
            size_q <= bus.arr_size;
            arr_q  <= bus.arr;
            mode_q <= bus.mode;
            pc_q   <= (bus.mode == MODE_TARGET) ? T_A : BR;
          end
          // BR is only entered from a source snapshot; the mode_q guard is defensive.
          BR:  pc_q <= (mode_q == MODE_TARGET) ? T_A : ((j_q <= size_q) ? A1 : BR2);
          A1:  begin a_q <= a_j; pc_q <= B1; end
          B1:  begin b_q <= elem_j; pc_q <= DONE; done_q <= 1'b1; end
          BR2: pc_q <= A2;
          A2:  begin a_q <= a_s; pc_q <= B2; end
          B2:  begin b_q <= elem_s; pc_q <= DONE; done_q <= 1'b1; end
          A3:  begin a_q <= a_j; pc_q <= B3; end
          B3:  begin b_q <= elem_j; pc_q <= DONE; done_q <= 1'b1; end
          T_A: begin a_q <= a_j; pc_q <= T_B; end
          T_B: begin
            b_q    <= (j_q <= size_q) ? elem_j : elem_s;
            pc_q   <= DONE;
            done_q <= 1'b1;
          end
          DONE: begin
            if (bus.start) pc_q <= INIT;
            else           done_q <= 1'b1;
          end
          default: pc_q <= INIT;
        endcase
      end
    end
  end

  assign bus.a       = a_q;
  assign bus.b       = b_q;
  assign bus.stutter = stutter_q;
  assign bus.done    = done_q;
  assign bus.pc      = pc_q;

endmodule

// File: tb/tb_stutter_codeblock_param.sv
// Directed + randomized bench for stutter_codeblock_param against a program-level reference model.
module tb_stutter_codeblock_param;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  stutter_codeblock_param_if #(.W(4), .N(4), .IW(2)) bus0 ();
  stutter_codeblock_param_if #(.W(4), .N(3), .IW(2)) bus1 ();

  stutter_codeblock_param #(.W(4), .N(4), .IW(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  stutter_codeblock_param #(.W(4), .N(3), .IW(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program semantics with plain integer arithmetic modulo 2^W.
  function automatic int model_a(input int a0, input int a1);
    int m = 1 << W;
    return ((2 * (a0 + 1)) * (((a1 + m - 1) % m) % 2)) % m;
  endfunction

  function automatic int model_b(input int e[4], input int n, input int j, input int s);
    int idx = (j <= s) ? j : s;
    return (idx < n) ? e[idx] : 0;
  endfunction

  function automatic logic [15:0] pack(input int e[4]);
    logic [15:0] p;
    for (int k = 0; k < 4; k++) p[k*4 +: 4] = 4'(e[k]);
    return p;
  endfunction

  task automatic restart0();
    bus0.start      = 1'b1;
    bus0.stutter_in = 1'b0;
    tick();
    chk("restart0.pc", 32'(bus0.pc), 0);
    chk("restart0.done", 32'(bus0.done), 0);
    bus0.start = 1'b0;
  endtask

  task automatic run0(input int e[4], input int j, input int s, input int mode,
                      input int pct, input string tag);
    int        exp_path[$];
    int        seen[$];
    int        nst = 0;
    int        cyc = 0;
    logic      s_in;
    logic [3:0] prev;
    if (mode != 0)  exp_path = '{10, 11, 9};
    else if (j <= s) exp_path = '{1, 2, 3, 9};
    else            exp_path = '{1, 4, 5, 6, 9};
    bus0.arr      = pack(e);
    bus0.j        = 2'(j);
    bus0.arr_size = 2'(s);
    bus0.mode     = 1'(mode);
    bus0.start    = 1'b0;
    chk({tag, ".pc_init"}, 32'(bus0.pc), 0);
    while (bus0.done !== 1'b1 && cyc < 60) begin
      s_in = ($urandom_range(99) < pct);
      bus0.stutter_in = s_in;
      prev = bus0.pc;
      tick();
      cyc++;
      chk({tag, ".stutter_echo"}, 32'(bus0.stutter), 32'(s_in));
      if (s_in) chk({tag, ".pc_frozen"}, 32'(bus0.pc), 32'(prev));
      else begin
        nst++;
        seen.push_back(int'(bus0.pc));
      end
      if (bus0.pc != 4'd0) begin
        bus0.arr      = 16'($urandom);
        bus0.j        = 2'($urandom_range(3));
        bus0.arr_size = 2'($urandom_range(3));
        bus0.mode     = 1'($urandom_range(1));
      end
    end
    bus0.stutter_in = 1'b0;
    chk({tag, ".done"}, 32'(bus0.done), 1);
    chk({tag, ".latency"}, 32'(nst), 32'(exp_path.size()));
    chk({tag, ".a"}, 32'(bus0.a), 32'(model_a(e[0], e[1])));
    chk({tag, ".b"}, 32'(bus0.b), 32'(model_b(e, 4, j, s)));
    for (int i = 0; i < exp_path.size(); i++)
      chk($sformatf("%s.path%0d", tag, i), (i < seen.size()) ? 32'(seen[i]) : 32'hFF,
          32'(exp_path[i]));
  endtask

  task automatic run1(input int e[4], input int j, input int s, input int mode, input string tag);
    int nst = 0;
    if (bus1.pc == 4'd9) begin
      bus1.start      = 1'b1;
      bus1.stutter_in = 1'b0;
      tick();
      bus1.start = 1'b0;
    end
    bus1.arr        = 12'(pack(e));
    bus1.j          = 2'(j);
    bus1.arr_size   = 2'(s);
    bus1.mode       = 1'(mode);
    bus1.stutter_in = 1'b0;
    chk({tag, ".pc_init"}, 32'(bus1.pc), 0);
    while (bus1.done !== 1'b1 && nst < 20) begin
      tick();
      nst++;
    end
    chk({tag, ".done"}, 32'(bus1.done), 1);
    chk({tag, ".latency"}, 32'(nst), (mode != 0) ? 3 : ((j <= s) ? 4 : 5));
    chk({tag, ".a"}, 32'(bus1.a), 32'(model_a(e[0], e[1])));
    chk({tag, ".b"}, 32'(bus1.b), 32'(model_b(e, 3, j, s)));
  endtask

  initial begin
    int e[4];
    int cyc;
    rst = 1'b1;
    bus0.stutter_in = 1'b0; bus0.start = 1'b0; bus0.mode = 1'b0;
    bus0.j = '0; bus0.arr_size = '0; bus0.arr = '0;
    bus1.stutter_in = 1'b1; bus1.start = 1'b0; bus1.mode = 1'b0;
    bus1.j = '0; bus1.arr_size = '0; bus1.arr = '0;
    #3;
    chk("reset.a", 32'(bus0.a), 0);
    chk("reset.b", 32'(bus0.b), 0);
    chk("reset.done", 32'(bus0.done), 0);
    chk("reset.stutter", 32'(bus0.stutter), 0);
    chk("reset.pc", 32'(bus0.pc), 0);
    #9 rst = 1'b0;

    run0('{3, 2, 0, 0}, 1, 2, 0, 0, "src_taken");
    restart0();
    run0('{3, 2, 0, 0}, 1, 2, 1, 0, "target");
    restart0();
    run0('{0, 5, 0, 0}, 3, 1, 0, 0, "src_else");
    restart0();
    run0('{3, 2, 9, 4}, 1, 2, 0, 50, "stut_src");
    restart0();
    run0('{3, 2, 9, 4}, 3, 1, 1, 50, "stut_tgt");
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) e[k] = int'($urandom_range(15));
      restart0();
      run0(e, int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(1)), 50,
           $sformatf("rand%0d", r));
    end

    chk("n3.held_in_init", 32'(bus1.pc), 0);
    run1('{7, 0, 5, 0}, 3, 3, 0, "n3_oob_src");
    run1('{7, 0, 5, 0}, 3, 3, 1, "n3_oob_tgt");
    run1('{2, 6, 11, 0}, 1, 2, 0, "n3_src");
    run1('{2, 6, 11, 0}, 3, 0, 1, "n3_tgt");

    // Leave a=8, b=2 in place, then reset while the else-path sits in A2.
    restart0();
    run0('{3, 2, 0, 0}, 1, 2, 0, 0, "pre_rst");
    restart0();
    bus0.arr = pack('{0, 5, 0, 0}); bus0.j = 2'd3; bus0.arr_size = 2'd1; bus0.mode = 1'b0;
    cyc = 0;
    while (bus0.pc !== 4'd5 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("mid.reach_a2", 32'(bus0.pc), 5);
    chk("mid.a_held", 32'(bus0.a), 8);
    bus0.stutter_in = 1'b1;
    tick();
    chk("mid.stutter", 32'(bus0.stutter), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.a", 32'(bus0.a), 0);
    chk("async_rst.b", 32'(bus0.b), 0);
    chk("async_rst.stutter", 32'(bus0.stutter), 0);
    chk("async_rst.done", 32'(bus0.done), 0);
    chk("async_rst.pc", 32'(bus0.pc), 0);
    #1 rst = 1'b0;
    bus0.stutter_in = 1'b0;
    run0('{1, 4, 0, 0}, 2, 3, 1, 0, "post_rst");

    bus0.start      = 1'b1;
    bus0.stutter_in = 1'b1;
    tick();
    chk("start_stut.pc", 32'(bus0.pc), 9);
    chk("start_stut.done", 32'(bus0.done), 1);
    bus0.stutter_in = 1'b0;
    tick();
    chk("start.pc", 32'(bus0.pc), 0);
    chk("start.done", 32'(bus0.done), 0);
    chk("start.a_kept", 32'(bus0.a), 32'(model_a(1, 4)));
    bus0.start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
